// File: rtl/dmem_hs.sv
// Word-addressed data memory with byte-enabled writes and a req/ready handshake.
// Each access takes a fixed number of wait states before it completes with a one-cycle ready pulse.
module dmem_hs #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req,
    input  logic               we,
    input  logic [WIDTH/8-1:0] be,
    input  logic [31:0]        a,
    input  logic [WIDTH-1:0]   wd,
    output logic [WIDTH-1:0]   rd,
    output logic               ready,
    output logic               err,
    output logic               busy
);

    localparam int NB  = WIDTH / 8;
    localparam int OFF = $clog2(NB);
    localparam int IW  = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [31:0]       addr_q, addr_d;
    logic              we_q, we_d;
    logic [NB-1:0]     be_q, be_d;
    logic [WIDTH-1:0]  wd_q, wd_d;
    logic [WIDTH-1:0]  rd_q, rd_d;
    logic              err_q, err_d;
    logic              mem_wr;
    logic [WIDTH-1:0]  mem_q [DEPTH];

    logic [31:0]       word_idx;
    logic [IW-1:0]     idx;
    logic              oor;

    // The full shifted address is compared so that high address bits flag an error instead of aliasing.
    assign word_idx = addr_q >> OFF;
    assign idx      = word_idx[IW-1:0];
    assign oor      = (word_idx >= 32'(DEPTH));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        we_d    = we_q;
        be_d    = be_q;
        wd_d    = wd_q;
        rd_d    = rd_q;
        err_d   = err_q;
        mem_wr  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    addr_d  = a;
                    we_d    = we;
                    be_d    = be;
                    wd_d    = wd;
                    cnt_d   = 3'(LATENCY);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q != 3'd0) begin
                    cnt_d = cnt_q - 3'd1;
                end else begin
                    state_d = DONE;
                    err_d   = oor;
                    if (we_q) begin
                        mem_wr = !oor && reset;
                    end else begin
                        rd_d = oor ? '0 : mem_q[idx];
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                err_d   = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            be_q    <= '0;
            wd_q    <= '0;
            rd_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            be_q    <= be_d;
            wd_q    <= wd_d;
            rd_q    <= rd_d;
            err_q   <= err_d;
        end
    end

    // Storage has no reset so its contents survive a reset pulse.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NB; i++) begin
            if (mem_wr && be_q[i]) begin
                mem_q[idx][i*8 +: 8] <= wd_q[i*8 +: 8];
            end
        end
    end

    assign rd    = rd_q;
    assign err   = err_q;
    assign ready = (state_q == DONE);
    assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_dmem_hs.sv
// Directed bench for dmem_hs: vector table on a default build plus latency-0/7 and 64-bit builds.
module tb_dmem_hs;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // default build (WIDTH=32, DEPTH=64, LATENCY=2)
    logic        req, we;
    logic [3:0]  be;
    logic [31:0] a, wd, rd;
    logic        ready, err, busy;

    // LATENCY=0 and LATENCY=7 builds share inputs
    logic        req_b, we_b;
    logic [3:0]  be_b;
    logic [31:0] a_b, wd_b, rd0, rd7;
    logic        rdy0, err0, busy0, rdy7, err7, busy7;

    // WIDTH=64 build
    logic        req_w, we_w;
    logic [7:0]  be_w;
    logic [31:0] a_w;
    logic [63:0] wd_w, rd_w;
    logic        rdy_w, err_w, busy_w;

    dmem_hs #(.WIDTH(32), .DEPTH(64), .LATENCY(2)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .be(be), .a(a), .wd(wd),
        .rd(rd), .ready(ready), .err(err), .busy(busy));

    dmem_hs #(.WIDTH(32), .DEPTH(64), .LATENCY(0)) dut_l0 (
        .clk(clk), .reset(reset), .req(req_b), .we(we_b), .be(be_b), .a(a_b), .wd(wd_b),
        .rd(rd0), .ready(rdy0), .err(err0), .busy(busy0));

    dmem_hs #(.WIDTH(32), .DEPTH(64), .LATENCY(7)) dut_l7 (
        .clk(clk), .reset(reset), .req(req_b), .we(we_b), .be(be_b), .a(a_b), .wd(wd_b),
        .rd(rd7), .ready(rdy7), .err(err7), .busy(busy7));

    dmem_hs #(.WIDTH(64), .DEPTH(64), .LATENCY(2)) dut_w64 (
        .clk(clk), .reset(reset), .req(req_w), .we(we_w), .be(be_w), .a(a_w), .wd(wd_w),
        .rd(rd_w), .ready(rdy_w), .err(err_w), .busy(busy_w));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic        w;
        logic [3:0]  b;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic w, input logic [3:0] b, input logic [31:0] addr,
                                input logic [31:0] data, input logic [31:0] erd, input logic eerr);
        vec_t v;
        v.w = w; v.b = b; v.addr = addr; v.data = data; v.exp_rd = erd; v.exp_err = eerr;
        vecs.push_back(v);
    endfunction

    // One access on the default build; inputs are scrambled while busy to show they are ignored.
    task automatic acc(input logic w, input logic [3:0] b, input logic [31:0] addr,
                       input logic [31:0] data, output logic [31:0] rdv, output logic ev,
                       output int lat);
        @(negedge clk);
        req = 1'b1; we = w; be = b; a = addr; wd = data;
        @(posedge clk); #1;
        check("busy_after_accept", busy, 1'b1);
        req = 1'b0; we = ~w; be = ~b; a = addr ^ 32'h0000_00F0; wd = ~data;
        lat = 0;
        while (!ready && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        rdv = rd; ev = err;
        @(posedge clk); #1;
    endtask

    task automatic acc64(input logic w, input logic [7:0] b, input logic [31:0] addr,
                         input logic [63:0] data, output logic [63:0] rdv, output logic ev,
                         output int lat);
        @(negedge clk);
        req_w = 1'b1; we_w = w; be_w = b; a_w = addr; wd_w = data;
        @(posedge clk); #1;
        req_w = 1'b0; wd_w = ~data; be_w = ~b;
        lat = 0;
        while (!rdy_w && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        rdv = rd_w; ev = err_w;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] r;
        logic [63:0] r64;
        logic        e;
        int          lat;
        int          last0, last7, cnt0, cnt7, stray;

        reset = 1'b0;
        req = 1'b0; we = 1'b0; be = '0; a = '0; wd = '0;
        req_b = 1'b0; we_b = 1'b0; be_b = '0; a_b = '0; wd_b = '0;
        req_w = 1'b0; we_w = 1'b0; be_w = '0; a_w = '0; wd_w = '0;
        #1;
        check("reset_ready", ready, 1'b0);
        check("reset_busy",  busy,  1'b0);
        check("reset_err",   err,   1'b0);
        check("reset_rd",    rd,    32'h0);
        @(negedge clk);
        reset = 1'b1;

        //   we    be     addr           wd             exp rd         exp err
        add(1'b1, 4'hF, 32'h0000_0010, 32'hDEADBEEF, 32'h0000_0000, 1'b0);
        add(1'b0, 4'h0, 32'h0000_0010, 32'h0,        32'hDEADBEEF, 1'b0);
        add(1'b1, 4'h3, 32'h0000_0010, 32'h00001234, 32'hDEADBEEF, 1'b0);
        add(1'b0, 4'hF, 32'h0000_0013, 32'h0,        32'hDEAD1234, 1'b0);
        add(1'b1, 4'hF, 32'h0000_0000, 32'h01234567, 32'hDEAD1234, 1'b0);
        add(1'b0, 4'hF, 32'h0000_0100, 32'h0,        32'h0000_0000, 1'b1);
        add(1'b1, 4'hF, 32'h0000_0100, 32'hFFFFFFFF, 32'h0000_0000, 1'b1);
        add(1'b0, 4'hF, 32'h0000_0000, 32'h0,        32'h01234567, 1'b0);
        add(1'b1, 4'hF, 32'h0000_0004, 32'hA5A5A5A5, 32'h01234567, 1'b0);
        add(1'b1, 4'h0, 32'h0000_0004, 32'hFFFFFFFF, 32'h01234567, 1'b0);
        add(1'b0, 4'hF, 32'h0000_0004, 32'h0,        32'hA5A5A5A5, 1'b0);
        add(1'b1, 4'hF, 32'h8000_0010, 32'h11111111, 32'hA5A5A5A5, 1'b1);
        add(1'b0, 4'hF, 32'h0000_0010, 32'h0,        32'hDEAD1234, 1'b0);
        add(1'b1, 4'hF, 32'h0000_00FC, 32'hCAFEF00D, 32'hDEAD1234, 1'b0);
        add(1'b0, 4'hF, 32'h0000_00FE, 32'h0,        32'hCAFEF00D, 1'b0);
        add(1'b0, 4'hF, 32'h0000_0400, 32'h0,        32'h0000_0000, 1'b1);
        add(1'b1, 4'hF, 32'h0000_0020, 32'h12345678, 32'h0000_0000, 1'b0);
        add(1'b0, 4'hF, 32'h0000_00FC, 32'h0,        32'hCAFEF00D, 1'b0);

        foreach (vecs[i]) begin
            acc(vecs[i].w, vecs[i].b, vecs[i].addr, vecs[i].data, r, e, lat);
            check($sformatf("v%0d_latency", i), 64'(lat), 64'd3);
            check($sformatf("v%0d_rd", i), r, vecs[i].exp_rd);
            check($sformatf("v%0d_err", i), e, vecs[i].exp_err);
        end

        // Reset one cycle after accepting a write: aborted, outputs cleared, old data kept.
        @(negedge clk);
        req = 1'b1; we = 1'b1; be = 4'hF; a = 32'h20; wd = 32'h55AA55AA;
        @(posedge clk); #1;
        req = 1'b0;
        check("abort_busy_before", busy, 1'b1);
        @(posedge clk); #2;
        reset = 1'b0;
        #1;
        check("abort_ready", ready, 1'b0);
        check("abort_busy",  busy,  1'b0);
        check("abort_err",   err,   1'b0);
        check("abort_rd",    rd,    32'h0);
        stray = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (ready) stray++;
        end
        check("abort_no_ready", 64'(stray), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        acc(1'b0, 4'hF, 32'h20, 32'h0, r, e, lat);
        check("abort_readback_latency", 64'(lat), 64'd3);
        check("abort_readback_rd", r, 32'h12345678);
        check("abort_readback_err", e, 1'b0);

        // req held high on the LATENCY=0 and LATENCY=7 builds.
        last0 = -1; last7 = -1; cnt0 = 0; cnt7 = 0;
        @(negedge clk);
        req_b = 1'b1; we_b = 1'b1; be_b = 4'hF; a_b = 32'h8; wd_b = 32'h0F0F0F0F;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (rdy0) begin
                if (last0 < 0) check("l0_first_ready", 64'(c), 64'd1);
                else           check("l0_spacing", 64'(c - last0), 64'd3);
                check("l0_busy_in_done", busy0, 1'b1);
                check("l0_err", err0, 1'b0);
                last0 = c; cnt0++;
            end
            if (rdy7) begin
                if (last7 < 0) check("l7_first_ready", 64'(c), 64'd8);
                else           check("l7_spacing", 64'(c - last7), 64'd10);
                check("l7_busy_in_done", busy7, 1'b1);
                check("l7_err", err7, 1'b0);
                last7 = c; cnt7++;
            end
        end
        req_b = 1'b0;
        check("l0_pulse_count", 64'(cnt0), 64'd13);
        check("l7_pulse_count", 64'(cnt7), 64'd4);
        repeat (12) @(posedge clk);

        // WIDTH=64 build: byte-lane writes and sub-word address aliasing within a word.
        acc64(1'b1, 8'hFF, 32'h8, 64'h0, r64, e, lat);
        acc64(1'b1, 8'h80, 32'h8, 64'hAB00_0000_0000_0000, r64, e, lat);
        acc64(1'b0, 8'h00, 32'h8, 64'h0, r64, e, lat);
        check("w64_rd_a8", r64, 64'hAB00_0000_0000_0000);
        check("w64_latency", 64'(lat), 64'd3);
        acc64(1'b0, 8'hFF, 32'hC, 64'h0, r64, e, lat);
        check("w64_rd_aC", r64, 64'hAB00_0000_0000_0000);
        check("w64_err_aC", e, 1'b0);
        acc64(1'b1, 8'hFF, 32'h10, 64'h1122_3344_5566_7788, r64, e, lat);
        acc64(1'b1, 8'h81, 32'h10, 64'hAB00_0000_0000_00CD, r64, e, lat);
        acc64(1'b0, 8'hFF, 32'h17, 64'h0, r64, e, lat);
        check("w64_rd_mixed", r64, 64'hAB22_3344_5566_77CD);
        acc64(1'b0, 8'hFF, 32'h200, 64'h0, r64, e, lat);
        check("w64_oor_rd", r64, 64'h0);
        check("w64_oor_err", e, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, actual timeout required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dmem_hs.md
DMEM_HS -- requirements
Module: dmem_hs

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data word width in bits (multiple of 8, 8..64).
REQ-002 SHALL have parameter DEPTH, default 64, number of words stored (power of two, 4..1024).
REQ-003 SHALL have parameter LATENCY, default 2, wait states per access (0..7).
REQ-004 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port req  input  1  access request, sampled only in IDLE.
REQ-007 SHALL have port we  input  1  1 = write, 0 = read; sampled with req.
REQ-008 SHALL have port be  input  WIDTH/8  byte enables for writes; bit i gates byte i.
REQ-009 SHALL have port a  input  32  byte address; word index = a >> log2(WIDTH/8), low bits ignored.
REQ-010 SHALL have port wd  input  WIDTH  write data.
REQ-011 SHALL have port rd  output  WIDTH  read data, valid while ready=1 after a read.
REQ-012 SHALL have port ready  output  1  one-cycle completion pulse.
REQ-013 SHALL have port err  output  1  out-of-range flag, valid only while ready=1.
REQ-014 SHALL have port busy  output  1  high in WAIT and DONE.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, DONE.
REQ-016 IDLE: req=1 at an edge SHALL capture a, we, be, wd into internal registers, load wait counter with LATENCY, and go to WAIT; req=0 stays in IDLE.
REQ-017 WAIT: counter != 0 at an edge SHALL decrement it and stay; counter == 0 SHALL perform the access and go to DONE.
REQ-018 DONE: SHALL drive ready=1 for exactly one cycle, then return to IDLE at the next edge.
REQ-019 Latency SHALL be LATENCY+1 edges from the accepting edge to the first cycle with ready=1; LATENCY=0 gives ready in the cycle after acceptance.
REQ-020 req, we, be, a, wd changes while busy=1 SHALL be ignored; req high during DONE SHALL NOT be accepted; minimum request spacing is LATENCY+3 cycles.
REQ-021 Write: each byte i with be[i]=1 SHALL be updated from the captured wd; bytes with be[i]=0 SHALL be unchanged; be=0 completes with no change.
REQ-022 Read: rd SHALL hold the full word at the captured index, registered at the access edge; be SHALL be ignored for reads.
REQ-023 rd SHALL keep its last value through writes and idle cycles; it changes only on a completed read.
REQ-024 Word index >= DEPTH: SHALL set err=1 with ready, suppress any write, and drive rd=0 for reads.
REQ-025 A read issued after a completed write to the same index SHALL return the written data.
REQ-026 Index arithmetic SHALL use only the captured address; bits above the index range SHALL cause err, never aliasing.

Reset
REQ-027 reset=0 SHALL force IDLE, counter=0, ready=0, err=0, busy=0, rd=0 immediately, independent of clk.
REQ-028 Reset mid-transaction SHALL abort it: no write performed, no ready pulse generated.
REQ-029 Memory array contents SHALL NOT be cleared by reset.
REQ-030 The first request SHALL be accepted at the first edge after reset deasserts with req=1.

Verification
REQ-031 LATENCY=2: write a=0x10, wd=0xDEADBEEF, be=0xF; read a=0x10 -> ready exactly 3 edges after each accept, rd=0xDEADBEEF, err=0.
REQ-032 Partial write a=0x10, be=0x3, wd=0x00001234 onto 0xDEADBEEF; read -> rd=0xDEAD1234.
REQ-033 DEPTH=64: read a=0x100 -> ready with err=1, rd=0; write a=0x100 -> err=1, then read a=0x0 returns prior contents unchanged.
REQ-034 Assert reset=0 one cycle after accepting a write to a=0x20 with wd=0x55AA55AA -> no ready pulse, outputs zeroed; subsequent read a=0x20 returns the old value.
REQ-035 LATENCY=0 and LATENCY=7 builds: back-to-back requests with req held high -> ready pulses spaced by LATENCY+3 cycles, no request accepted while busy=1.
REQ-036 WIDTH=64: write a=0x8, be=0x80, wd=0xAB00000000000000 onto zeroed word -> read rd=0xAB00000000000000; a=0xC maps to the same word.
